// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and data stages.
// Optional per-stage wait counters are built when MEM_ARBITER_PERF_EN is defined.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stall
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0]         perf_if_wait,
    output logic [31:0]         perf_d_wait
`endif
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t state;
    logic   last_d;
    logic   grant_i;

    // data has priority unless the previous grant went to data and a fetch is waiting
    assign grant_i = if_req & (~d_req | last_d);
    assign stall   = (if_req & ~if_ack) | (d_req & ~d_ack);

    // arbitration, memory transaction sequencing and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (if_req | d_req) begin
                    state     <= grant_i ? BUSY_I : BUSY_D;
                    last_d    <= ~grant_i;
                    mem_req   <= 1'b1;
                    mem_we    <= ~grant_i & d_we;
                    mem_be    <= (grant_i | ~d_we) ? {BE_W{1'b1}} : d_be;
                    mem_addr  <= grant_i ? if_addr : d_addr;
                    mem_wdata <= grant_i ? '0 : d_wdata;
                end
                BUSY_I, BUSY_D: if (mem_ack) begin
                    state   <= DONE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    if (state == BUSY_I) begin
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                    end else begin
                        d_rdata <= mem_rdata;
                        d_ack   <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    // saturating counts of cycles each stage spends waiting on its ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_wait <= '0;
            perf_d_wait  <= '0;
        end else begin
            if (if_req & ~if_ack & ~&perf_if_wait) perf_if_wait <= perf_if_wait + 32'd1;
            if (d_req & ~d_ack & ~&perf_d_wait) perf_d_wait <= perf_d_wait + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack, d_ack, mem_req, mem_we, stall;
    logic [3:0]  mem_be;
`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] perf_if_wait, perf_d_wait;
`endif

    int          checks = 0;
    int          failures = 0;
    logic        m_last_d;
    logic [31:0] m_if_rdata, m_d_rdata;
    bit          won;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall)
`ifdef MEM_ARBITER_PERF_EN
        , .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom);
        d_be    = 4'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
    endtask

    // Called at the negedge of an idle arbiter cycle with requests applied; returns at the
    // negedge of the cycle carrying the ack. w = memory wait cycles, drop = requester
    // withdraws right after the grant.
    task automatic run_txn(input int w, input bit drop, input logic [31:0] rdv, output bit gi);
        logic [31:0] ea, ew;
        logic [3:0]  eb;
        logic        ewe;
        #1;
        chk("idle_mem_req", mem_req, 1'b0);
        chk("idle_acks", {if_ack, d_ack}, 2'b00);
        chk("idle_stall", stall, if_req | d_req);
        gi       = if_req && (!d_req || m_last_d);
        m_last_d = !gi;
        ea       = gi ? if_addr : d_addr;
        ewe      = gi ? 1'b0 : d_we;
        eb       = (gi || !d_we) ? 4'hF : d_be;
        ew       = d_wdata;
        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            chk("busy_mem_req", mem_req, 1'b1);
            chk("busy_addr", mem_addr, ea);
            chk("busy_we", mem_we, ewe);
            chk("busy_be", mem_be, eb);
            if (ewe) chk("busy_wdata", mem_wdata, ew);
            chk("busy_acks", {if_ack, d_ack}, 2'b00);
            chk("busy_stall", stall, if_req | d_req);
            if (drop && k == 0) begin
                if (gi) if_req = 1'b0;
                else begin
                    d_req   = 1'b0;
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end
            end
            if (k == w) begin
                mem_rdata = rdv;
                mem_ack   = 1'b1;
            end
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (gi) m_if_rdata = rdv;
        else m_d_rdata = rdv;
        chk("done_mem_req", mem_req, 1'b0);
        chk("done_mem_we", mem_we, 1'b0);
        chk("done_if_ack", if_ack, gi);
        chk("done_d_ack", d_ack, !gi);
        chk("done_if_rdata", if_rdata, m_if_rdata);
        chk("done_d_rdata", d_rdata, m_d_rdata);
        chk("done_stall", stall, (if_req & !gi) | (d_req & gi));
    endtask

    initial begin
        rst = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0; d_be = 0;
        m_last_d = 0; m_if_rdata = 0; m_d_rdata = 0;

        // reset hold and release
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem", {mem_req, mem_we, mem_be, mem_addr}, 0);
        chk("rst_acks", {if_ack, d_ack, stall}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_mem", {mem_req, mem_we, mem_be, mem_addr}, 0);
        chk("rel_wdata", mem_wdata, 0);
        chk("rel_rdata", {if_rdata, d_rdata}, 0);
        chk("rel_acks", {if_ack, d_ack, stall}, 0);

        // single zero-wait load
        d_req = 1; d_we = 0; d_be = 4'h0; d_addr = 32'h40; d_wdata = 0;
        run_txn(0, 0, 32'hDEADBEEF, won);
        d_req = 0;
        @(negedge clk);

        // store with waits, then a fetch
        d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h100; d_wdata = 32'h1234ABCD;
        run_txn(2, 0, $urandom, won);
        d_req = 0; new_if();
        @(negedge clk);
        run_txn(0, 0, $urandom, won);
        if_req = 0;
        @(negedge clk);

        // contention with both stages held
        new_if(); new_d();
        for (int n = 0; n < 4; n++) begin
            run_txn(2, 0, $urandom, won);
            if (won) new_if(); else new_d();
            @(negedge clk);
        end
        if (won) if_req = 0; else d_req = 0;
        run_txn(2, 0, $urandom, won);
        if_req = 0; d_req = 0;
        @(negedge clk);

        // reset during a fetch before the memory responds
        new_if();
        #1;
        @(negedge clk);
        chk("abort_busy_req", mem_req, 1'b1);
        rst = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 1'b0);
        chk("abort_if_ack", if_ack, 1'b0);
        @(negedge clk);
        chk("abort_hold", {mem_req, if_ack, d_ack}, 0);
        rst = 1'b1;
        m_last_d = 0; m_if_rdata = 0; m_d_rdata = 0;
        run_txn(1, 0, $urandom, won);
        if_req = 0;
        @(negedge clk);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            while (!if_req && !d_req) begin
                logic [1:0] r;
                chk("quiet_mem_req", mem_req, 1'b0);
                chk("quiet_stall", stall, 1'b0);
                r = 2'($urandom);
                if (r[0]) new_if();
                if (r[1]) new_d();
                if (!if_req && !d_req) @(negedge clk);
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 9) == 0, $urandom, won);
            if (won) begin
                if ($urandom_range(0, 1) == 1) new_if(); else if_req = 0;
            end else begin
                if ($urandom_range(0, 1) == 1) new_d(); else d_req = 0;
            end
            @(negedge clk);
        end
        if_req = 0; d_req = 0;

`ifdef MEM_ARBITER_PERF_EN
        // fetch waiting behind one data access
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_last_d = 0; m_if_rdata = 0; m_d_rdata = 0;
        new_if(); new_d();
        run_txn(0, 0, $urandom, won);
        d_req = 0;
        @(negedge clk);
        run_txn(0, 0, $urandom, won);
        chk("perf_if_wait", perf_if_wait, 32'd5);
        chk("perf_d_wait", perf_d_wait, 32'd2);
        if_req = 0;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
